if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding
// request/response handshake with instruction memory and presents the
// fetched instruction to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrF,
    output logic [31:0] PCF,
    output logic [31:0] PCplus4F,
    output logic        fetch_valid,
    output logic        bubble_req
);

    // REQ: request pending, WAIT: granted awaiting data, HOLD: instruction
    // held for ID, KILL: draining a response that belongs to a dropped fetch.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_buf, instr_buf_n;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    // State, PC and instruction buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            instr_buf <= NOP_INSTR;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            instr_buf <= instr_buf_n;
        end
    end

    // Next-state logic: redirect has priority over stall and handshake.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        instr_buf_n = instr_buf;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = imem_gnt ? S_KILL : S_REQ;
                end else if (imem_gnt) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = imem_rvalid ? S_REQ : S_KILL;
                end else if (imem_rvalid) begin
                    instr_buf_n = imem_rdata;
                    state_n     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_n        = target;
                    instr_buf_n = NOP_INSTR;
                    state_n     = S_REQ;
                end else if (!stallF) begin
                    pc_n    = pc + 32'd4;
                    state_n = S_REQ;
                end
            end
            S_KILL: begin
                if (redirect_valid) begin
                    pc_n = target;
                end
                if (imem_rvalid) begin
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        imem_req    = (state == S_REQ) && !rst;
        imem_addr   = pc;
        fetch_valid = (state == S_HOLD);
        bubble_req  = !fetch_valid;
        instrF      = fetch_valid ? instr_buf : NOP_INSTR;
        PCF         = pc;
        PCplus4F    = pc + 32'd4;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. Expected fetches are queued
// when memory data is driven and compared when the DUT presents them.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic [31:0] PCplus4F;
    logic        fetch_valid;
    logic        bubble_req;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t sb[$];

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallF        (stallF),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instrF        (instrF),
        .PCF           (PCF),
        .PCplus4F      (PCplus4F),
        .fetch_valid   (fetch_valid),
        .bubble_req    (bubble_req)
    );

    always #5 clk = ~clk;

    // Advance one active edge; inputs change and outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] pc, input logic [31:0] instr);
        fetch_t f;
        f.pc    = pc;
        f.instr = instr;
        sb.push_back(f);
    endtask

    // Wait (bounded) for a presented instruction and compare it with the queue head.
    task automatic wait_fetch(input string tag, input int budget);
        fetch_t f;
        for (int i = 0; i < budget && fetch_valid !== 1'b1; i++) tick();
        chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            f = sb.pop_front();
            chk({tag, "_instr"}, instrF, f.instr);
            chk({tag, "_pc"}, PCF, f.pc);
            chk({tag, "_pc4"}, PCplus4F, f.pc + 32'd4);
            chk({tag, "_bubble"}, {31'd0, bubble_req}, 32'd0);
        end
    endtask

    // One full fetch with immediate grant and one-cycle data return.
    task automatic do_fetch(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = instr;
        push_fetch(pc, instr);
        tick();
        imem_rvalid = 1'b0;
        wait_fetch(tag, 4);
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_fv",     {31'd0, fetch_valid}, 32'd0);
        chk("rst_bubble", {31'd0, bubble_req}, 32'd1);
        chk("rst_pcf",    PCF, 32'h0);
        chk("rst_pc4",    PCplus4F, 32'h4);
        chk("rst_instr",  instrF, 32'h13);
        chk("rst_req",    {31'd0, imem_req}, 32'd1);
        chk("rst_addr",   imem_addr, 32'h0);

        // First fetch, then stall three cycles in HOLD.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("f1_wait_fv",    {31'd0, fetch_valid}, 32'd0);
        chk("f1_wait_instr", instrF, 32'h13);
        chk("f1_wait_req",   {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        push_fetch(32'h0, 32'h0050_0093);
        stallF = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        wait_fetch("f1", 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_fv",    {31'd0, fetch_valid}, 32'd1);
            chk("stall_instr", instrF, 32'h0050_0093);
            chk("stall_pcf",   PCF, 32'h0);
        end
        stallF = 1'b0;
        tick();
        chk("consume_addr", imem_addr, 32'h4);
        chk("consume_req",  {31'd0, imem_req}, 32'd1);

        do_fetch("f2", 32'h4, 32'h00A0_0113);
        tick();
        chk("f2_next_addr", imem_addr, 32'h8);

        // Redirect while the request to 0x8 is outstanding.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("kill_fv",  {31'd0, fetch_valid}, 32'd0);
        chk("kill_req", {31'd0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("killdrop_fv",    {31'd0, fetch_valid}, 32'd0);
        chk("killdrop_instr", instrF, 32'h13);
        chk("killdrop_req",   {31'd0, imem_req}, 32'd1);
        chk("killdrop_addr",  imem_addr, 32'h40);

        // Redirect overrides a stalled HOLD; low target bits are dropped.
        do_fetch("f3", 32'h40, 32'h0010_0193);
        stallF = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        stallF = 1'b0;
        chk("hredir_fv",   {31'd0, fetch_valid}, 32'd0);
        chk("hredir_req",  {31'd0, imem_req}, 32'd1);
        chk("hredir_addr", imem_addr, 32'h100);

        // Wrap at the top of the address space and spurious rvalid in REQ.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4",  PCplus4F, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        tick();
        imem_rvalid = 1'b0;
        chk("spur_fv",  {31'd0, fetch_valid}, 32'd0);
        chk("spur_req", {31'd0, imem_req}, 32'd1);
        do_fetch("f4", 32'hFFFF_FFFC, 32'h0020_0213);
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset while in WAIT, with rvalid in the first post-reset cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("prerst_addr", imem_addr, 32'h200);
        rst = 1'b1;
        tick();
        #1;
        chk("inrst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD1_1BAD;
        #1;
        chk("postrst_req",  {31'd0, imem_req}, 32'd1);
        chk("postrst_addr", imem_addr, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        chk("postrst_fv",   {31'd0, fetch_valid}, 32'd0);
        chk("postrst_req2", {31'd0, imem_req}, 32'd1);
        do_fetch("f5", 32'h0, 32'h0030_0293);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
